// File: rtl/onchip_sample_streamer.sv
// onchip_sample_streamer: Avalon-MM read master that streams a word window of the sample RAM through a FIFO.
module onchip_sample_streamer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_valid,
  input  logic              smp_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;
  state_e            state_q;
  logic [ADDR_W-1:0] base_q, len_q, addr_q, remain_q;
  logic              loop_q, inflight_q, done_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CW:0]       credit;
  logic              pop, push, issue, last;
  assign pop     = smp_valid & smp_ready;
  assign push    = inflight_q & ~stop;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // Queued words plus the outstanding read must leave room for the new read.
  assign credit  = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue   = (state_q == FETCH) && !stop && (credit < (CW+1)'(FIFO_DEPTH));
  assign last    = remain_q == ADDR_W'(1);
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign smp_data       = mem_q[rd_q];
  assign smp_valid      = count_q != '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      loop_q     <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      count_q    <= count_d;
      if (issue) begin
        addr_q   <= (last && loop_q) ? base_q : addr_q + ADDR_W'(1);
        remain_q <= (last && loop_q) ? len_q : remain_q - ADDR_W'(1);
      end
      if (push) begin
        mem_q[wr_q] <= mem_readdata;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      if (stop) begin
        if (state_q != IDLE) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          count_q <= '0;
          rd_q    <= '0;
          wr_q    <= '0;
        end
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (num_words != '0) begin
              base_q   <= base_addr;
              len_q    <= num_words;
              loop_q   <= loop;
              addr_q   <= base_addr;
              remain_q <= num_words;
              state_q  <= FETCH;
            end else done_q <= 1'b1;
          end
          FETCH: if (issue && last && !loop_q) state_q <= DRAIN;
          DRAIN: if (!inflight_q && count_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule
